// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the LEGv8 run/halt sequencer: sequencer states, the
// default halt encoding and the dump-length width rule.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CRST     = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_OUT = 3'd5,
        S_DONE     = 3'd6
    } run_state_e;

    // B #0: the program spins on itself, used as the end-of-program marker
    localparam logic [31:0] HALT_INST_DEF = 32'h1400_0000;

    // One extra bit so a length of exactly 2^addr_w words is representable
    function automatic int unsigned dump_len_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Data-memory takeover port and dump stream of the run/halt sequencer.
interface cpu_run_ctrl_if;

    logic        mem_sel;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;

    logic [63:0] dump_data;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_last;

    modport master (
        output mem_sel, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last,
        input  mem_rdata, dump_ready
    );

    modport slave (
        input  mem_sel, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last,
        output mem_rdata, dump_ready
    );

endinterface

// File: rtl/cpu_run_ctrl_dump.sv
// Dump engine: walks a wrapping window of data memory, one outstanding read,
// and presents each word on a valid/ready stream held stable until accepted.
module cpu_run_ctrl_dump
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    localparam int unsigned LEN_W = dump_len_w(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              mem_rd_en,
    output logic [63:0]       mem_addr,
    input  logic [63:0]       mem_rdata,
    output logic [63:0]       dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last,
    output logic              word_ack,
    output logic              fin
);

    logic [ADDR_W-1:0] rd_idx;
    logic [LEN_W-1:0]  word_i;
    logic              rd_pend;

    assign word_ack = dump_valid && dump_ready;
    assign fin      = word_ack && dump_last;
    assign mem_addr = {{(64 - ADDR_W - 3){1'b0}}, rd_idx, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx     <= '0;
            word_i     <= '0;
            rd_pend    <= 1'b0;
            mem_rd_en  <= 1'b0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            rd_pend   <= mem_rd_en;

            // The index is ADDR_W bits wide, so base+i wraps at the top of memory
            if (go) begin
                rd_idx    <= base;
                word_i    <= '0;
                mem_rd_en <= 1'b1;
            end else if (word_ack && !dump_last) begin
                rd_idx    <= rd_idx + 1'b1;
                word_i    <= word_i + 1'b1;
                mem_rd_en <= 1'b1;
            end

            if (rd_pend) begin
                dump_data  <= mem_rdata;
                dump_valid <= 1'b1;
                dump_last  <= (word_i == len - 1'b1);
            end else if (word_ack) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer: holds the core in reset until start, catches the halt
// instruction at fetch, drains the pipe, then streams a data-memory window out.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter logic [31:0] HALT_INST    = HALT_INST_DEF,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYC  = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    input  logic [31:0]       cpu_inst,
    output logic              cpu_rst_n,
    output logic              cpu_fetch_hold,
    cpu_run_ctrl_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_cnt
);

    localparam int unsigned LEN_W   = dump_len_w(ADDR_W);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [31:0]        TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX      = {1'b1, {ADDR_W{1'b0}}};

    run_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic              start_ok;
    logic              dump_go;
    logic              word_ack;
    logic              dump_fin;

    logic              rd_en;
    logic [63:0]       rd_addr;
    logic [63:0]       out_data;
    logic              out_valid;
    logic              out_last;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        dump_go = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_CRST;
            S_CRST:         state_d = S_RUN;
            // Halt is checked first so it wins on the final watchdog cycle
            S_RUN: begin
                if (cpu_inst == HALT_INST)
                    state_d = S_DRAIN;
                else if (cycle_cnt == TIMEOUT_LAST)
                    state_d = S_DONE;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DUMP_RD;
                        dump_go = 1'b1;
                    end
                end
            end
            S_DUMP_RD:  state_d = S_DUMP_OUT;
            S_DUMP_OUT: if (word_ack) state_d = dump_fin ? S_DONE : S_DUMP_RD;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state into flops so each one is a clean register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            drain_cnt      <= '0;
            cycle_cnt      <= '0;
            timeout        <= 1'b0;
            cpu_rst_n      <= 1'b0;
            cpu_fetch_hold <= 1'b1;
            bus.mem_sel    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cpu_rst_n      <= !(state_d inside {S_IDLE, S_CRST});
            cpu_fetch_hold <= (state_d != S_RUN);
            bus.mem_sel    <= (state_d inside {S_DUMP_RD, S_DUMP_OUT});
            busy           <= (state_d inside {S_CRST, S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_OUT});
            done           <= (state_d == S_DONE);
            drain_cnt      <= (state_q == S_DRAIN) ? drain_cnt + 1'b1 : '0;

            if (start_ok) begin
                base_q    <= dump_base;
                len_q     <= (dump_len > LEN_MAX) ? LEN_MAX : dump_len;
                cycle_cnt <= '0;
                timeout   <= 1'b0;
            end

            if (state_q == S_RUN) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (state_d == S_DONE)
                    timeout <= 1'b1;
            end
        end
    end

    cpu_run_ctrl_dump #(
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (dump_go),
        .base       (base_q),
        .len        (len_q),
        .mem_rd_en  (rd_en),
        .mem_addr   (rd_addr),
        .mem_rdata  (bus.mem_rdata),
        .dump_data  (out_data),
        .dump_valid (out_valid),
        .dump_ready (bus.dump_ready),
        .dump_last  (out_last),
        .word_ack   (word_ack),
        .fin        (dump_fin)
    );

    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = rd_addr;
    assign bus.dump_data  = out_data;
    assign bus.dump_valid = out_valid;
    assign bus.dump_last  = out_last;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed and random runs checked against a
// run-level model (halt cycle, window contents, wrap, watchdog, drain length).
module tb_cpu_run_ctrl;

    localparam int          TMO   = 50;
    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'h1400_0000;

    logic        tb_clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  dump_base;
    logic [10:0] dump_len;
    logic [31:0] cpu_inst;
    logic        cpu_rst_n;
    logic        cpu_fetch_hold;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_cnt;

    int          vectors;
    int          miscompares;
    logic [63:0] salt;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(
        .ADDR_W       (10),
        .HALT_INST    (HALT),
        .DRAIN_CYCLES (DRAIN),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk            (tb_clk),
        .rst_n          (rst_n),
        .start          (start),
        .dump_base      (dump_base),
        .dump_len       (dump_len),
        .cpu_inst       (cpu_inst),
        .cpu_rst_n      (cpu_rst_n),
        .cpu_fetch_hold (cpu_fetch_hold),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycle_cnt      (cycle_cnt)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    function automatic logic [63:0] memf(input logic [9:0] i);
        return (64'(i) * 64'h10) ^ salt;
    endfunction

    // Data memory: read data appears the cycle after the strobe, noise otherwise
    always @(posedge tb_clk) begin
        if (bus.mem_rd_en)
            bus.mem_rdata <= memf(bus.mem_addr[12:3]);
        else
            bus.mem_rdata <= {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".cpu_rst_n"}, cpu_rst_n, 0);
        chk({tag, ".hold"}, cpu_fetch_hold, 1);
        chk({tag, ".mem_sel"}, bus.mem_sel, 0);
        chk({tag, ".mem_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 0);
        chk({tag, ".dump_valid"}, bus.dump_valid, 0);
        chk({tag, ".dump_last"}, bus.dump_last, 0);
        chk({tag, ".dump_data"}, bus.dump_data, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".cycle_cnt"}, cycle_cnt, 0);
    endtask

    // h = RUN cycle (1-based) on which HALT sits at fetch; 0 = never.
    // rmode: 0 ready=1, 1 ready pattern 1-0-0-1, 2 random. abort_word >= 0 pulses
    // reset while that word is being offered.
    task automatic run_case(input logic [9:0] b, input logic [10:0] l, input int h,
                            input int rmode, input logic [63:0] s, input int abort_word);
        bit          exp_to;
        int          eff_len, exp_words, exp_run, exp_drain;
        int          run_cyc, drain_seen, rd_k, wk, cyc, rcnt;
        logic [63:0] prev_data;
        logic        prev_valid, prev_ready, prev_last;
        logic [9:0]  idx;

        exp_to    = (h <= 0) || (h > TMO);
        eff_len   = (l > 11'd1024) ? 1024 : int'(l);
        exp_words = exp_to ? 0 : eff_len;
        exp_run   = exp_to ? TMO : h;
        exp_drain = exp_to ? 0 : DRAIN;
        salt      = s;

        dump_base = b;
        dump_len  = l;
        start     = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        chk("crst.cpu_rst_n", cpu_rst_n, 0);
        chk("crst.busy", busy, 1);
        chk("crst.done", done, 0);
        chk("crst.timeout", timeout, 0);
        chk("crst.cycle_cnt", cycle_cnt, 0);

        run_cyc = 0; drain_seen = 0; rd_k = 0; wk = 0; cyc = 0; rcnt = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;

        while (!done && cyc < 5000) begin
            if (abort_word >= 0 && bus.dump_valid && wk == abort_word) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset("abort");
                @(negedge tb_clk);
                rst_n = 1'b1;
                return;
            end

            if (cpu_rst_n && !cpu_fetch_hold) begin
                run_cyc++;
                chk("run.cycle_cnt", cycle_cnt, 64'(run_cyc - 1));
                chk("run.mem_sel", bus.mem_sel, 0);
                cpu_inst = (run_cyc == h) ? HALT : ($urandom | 32'h1);
            end else begin
                cpu_inst = $urandom | 32'h1;
            end

            if (cpu_rst_n && cpu_fetch_hold && busy && !bus.mem_sel)
                drain_seen++;

            if (bus.mem_rd_en) begin
                idx = 10'(int'(b) + rd_k);
                chk("rd.in_window", rd_k < exp_words, 1);
                chk("rd.mem_sel", bus.mem_sel, 1);
                chk("rd.mem_addr", bus.mem_addr, 64'(idx) << 3);
                rd_k++;
            end

            if (prev_valid && !prev_ready) begin
                chk("hold.valid", bus.dump_valid, 1);
                chk("hold.data", bus.dump_data, prev_data);
                chk("hold.last", bus.dump_last, prev_last);
            end

            case (rmode)
                0:       bus.dump_ready = 1'b1;
                1:       bus.dump_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                default: bus.dump_ready = 1'($urandom_range(0, 1));
            endcase
            rcnt++;

            if (bus.dump_valid && bus.dump_ready) begin
                idx = 10'(int'(b) + wk);
                chk("out.in_window", wk < exp_words, 1);
                chk("out.data", bus.dump_data, memf(idx));
                chk("out.last", bus.dump_last, (wk == exp_words - 1));
                wk++;
            end

            prev_valid = bus.dump_valid;
            prev_ready = bus.dump_ready;
            prev_last  = bus.dump_last;
            prev_data  = bus.dump_data;

            // Latched window must ignore later input changes and stray starts
            start     = ($urandom_range(0, 7) == 0);
            dump_base = 10'($urandom);
            dump_len  = 11'($urandom);

            @(negedge tb_clk);
            cyc++;
        end
        start = 1'b0;

        chk("end.done", done, 1);
        chk("end.busy", busy, 0);
        chk("end.timeout", timeout, exp_to);
        chk("end.cycle_cnt", cycle_cnt, 64'(exp_run));
        chk("end.run_cycles", run_cyc, exp_run);
        chk("end.drain_cycles", drain_seen, exp_drain);
        chk("end.words", wk, exp_words);
        chk("end.reads", rd_k, exp_words);
        chk("end.cpu_rst_n", cpu_rst_n, 1);
        chk("end.hold", cpu_fetch_hold, 1);
        chk("end.mem_sel", bus.mem_sel, 0);
        chk("end.dump_valid", bus.dump_valid, 0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        salt           = '0;
        rst_n          = 1'b0;
        start          = 1'b0;
        dump_base      = '0;
        dump_len       = '0;
        cpu_inst       = 32'h1;
        bus.dump_ready = 1'b0;

        repeat (3) @(negedge tb_clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge tb_clk);
        check_reset("idle");

        run_case(10'd3, 11'd4, 10, 0, 64'h0, -1);
        run_case(10'd3, 11'd4, 10, 1, 64'h0, -1);
        run_case(10'd1022, 11'd4, 7, 0, 64'h0, -1);
        run_case(10'd5, 11'd5, 0, 0, 64'h0, -1);
        run_case(10'd9, 11'd3, TMO, 0, 64'h0, -1);
        run_case(10'd100, 11'd0, 5, 0, 64'h0, -1);
        run_case(10'd3, 11'd4, 10, 0, 64'h0, 1);
        run_case(10'd3, 11'd4, 10, 0, 64'h0, -1);
        run_case(10'd20, 11'd1500, 12, 0, {$urandom, $urandom}, -1);

        for (int n = 0; n < 12; n++) begin
            run_case(10'($urandom), 11'($urandom_range(0, 12)), int'($urandom_range(1, 60)),
                     2, {$urandom, $urandom}, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt sequencer for the LEGv8 core, single-cycle or pipeline.
- Holds the core in reset until `start`, then releases it.
- Detects the halt instruction (B #0) at fetch, freezes fetch and lets in-flight instructions drain.
- Takes over the data-memory port and streams a programmable window of data memory out over a valid/ready port.
- Replaces the bench-side halt watch and hierarchical memory peeking; also provides a cycle counter and a watchdog.

Parameters:
- ADDR_W, 10: data-memory word-index width (depth 2^ADDR_W).
- HALT_INST, 32'h1400_0000: encoding that marks program end.
- DRAIN_CYCLES, 4: cycles between halt detection and memory takeover. Use 1 for single-cycle, 4 for the pipeline.
- TIMEOUT_CYC, 10_000_000: maximum RUN cycles before the watchdog fires.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin a run
- dump_base  in  ADDR_W  first word index to dump; latched on start
- dump_len  in  ADDR_W+1  number of words to dump; latched on start
- cpu_inst  in  32  instruction currently at fetch
- cpu_rst_n  out  1  core reset, active-low
- cpu_fetch_hold  out  1  freezes PC and IF/ID; downstream stages keep running
- mem_sel  out  1  0 = core owns the data memory, 1 = dump engine owns it
- mem_rd_en  out  1  dump read strobe
- mem_addr  out  64  dump byte address = {index, 3'b000}, zero-extended
- mem_rdata  in  64  memory read data, valid the cycle after mem_rd_en
- dump_data  out  64  streamed word
- dump_valid  out  1  dump_data valid
- dump_ready  in  1  sink accepts
- dump_last  out  1  qualifies the final word
- busy  out  1  high in CRST, RUN, DRAIN, DUMP_RD, DUMP_OUT
- done  out  1  high in DONE
- timeout  out  1  sticky until next start; watchdog fired
- cycle_cnt  out  32  RUN cycles of the current/last run

Behaviour:
- Everything is registered; no combinational path from input to output.
- Reset values:
  - cpu_rst_n = 0, cpu_fetch_hold = 1, mem_sel = 0, mem_rd_en = 0, mem_addr = 0.
  - dump_valid = 0, dump_last = 0, dump_data = 0.
  - busy = 0, done = 0, timeout = 0, cycle_cnt = 0.
  - State = IDLE.
- IDLE: cpu_rst_n = 0, hold = 1.
  - start: latch base and len (len clamped to 2^ADDR_W), clear cycle_cnt, done and timeout; go to CRST.
- CRST (1 cycle): cpu_rst_n = 0; go to RUN.
- RUN: cpu_rst_n = 1, hold = 0, cycle_cnt += 1 per cycle.
  - cpu_inst == HALT_INST: go to DRAIN, hold = 1 from the next cycle. The halt instruction is never executed past fetch.
  - cycle_cnt == TIMEOUT_CYC-1 with no halt: timeout = 1, hold = 1, go to DONE, no dump.
  - Halt wins over timeout when both occur in the same cycle.
- DRAIN: hold = 1, cycle_cnt frozen.
  - Count DRAIN_CYCLES cycles, then go to DUMP_RD, or to DONE if len == 0.
  - mem_sel switches to 1 on entry to DUMP_RD.
- DUMP_RD (1 cycle): mem_rd_en = 1, mem_addr = {(base+i) mod 2^ADDR_W, 3'b000}.
  - The index wraps from 2^ADDR_W-1 to 0.
- DUMP_OUT: the cycle after entry, dump_data = mem_rdata (captured) and dump_valid = 1. dump_last = (i == len-1).
  - dump_data, dump_valid and dump_last are held stable until dump_ready.
  - On handshake: i += 1. If not last, go to DUMP_RD; else dump_valid = 0 and go to DONE.
  - One outstanding read; peak rate is 1 word per 3 cycles.
- DONE: done = 1, hold = 1, cpu_rst_n = 1, mem_sel = 0.
  - start: same as start from IDLE, then CRST.
- start is ignored in CRST, RUN, DRAIN, DUMP_RD and DUMP_OUT.
- rst_n asserted mid-run or mid-dump: immediate return to reset values. No partial word is emitted after reset.
- dump_ready while dump_valid = 0 is ignored.

Decomposition:
- Shared header common.vh gets:
  - `HALT_INST
  - state encodings (IDLE, CRST, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE; 3-bit)
  - `DUMP_LEN_W
- One natural sub-module, cpu_run_ctrl_dump: index/count registers, read strobe, output skid register and valid/ready logic. It has a start/finish handshake with the top FSM.
- Cycle counter and watchdog stay in the top module.

Test Plan:
- Reset, then start with base = 3, len = 4; cpu_inst = HALT at RUN cycle 10; mem_rdata = 0x10·index; dump_ready tied 1:
  - dump_data = 0x30, 0x40, 0x50, 0x60, with dump_last on 0x60.
  - cycle_cnt = 10, then done = 1.
- Same run with dump_ready toggling 1-0-0-1:
  - dump_data/dump_valid stable while dump_ready = 0; no word lost or duplicated.
- base = 1022, len = 4:
  - mem_addr sequence = 0x1FF0, 0x1FF8, 0x0000, 0x0008.
- Parameter TIMEOUT_CYC = 50, HALT never presented:
  - timeout = 1 and done = 1 after 50 RUN cycles; mem_rd_en never asserted.
- len = 0 with halt:
  - DRAIN (4 cycles) then DONE; dump_valid never asserted.
- rst_n pulsed low in the middle of the second dump word:
  - all outputs return to reset values.
  - A new start then replays the full dump from word 0.
